unary_decode_array: RTL and testbench

Bit-parallel unary-to-binary decoder for the uBrain datapath. It is the receiving end of the shared-RNG encoding array. Each of LANES input bitstreams was produced by comparing a binary source against a shared Sobol sequence. Over one full RNG period of 2^RWID cycles, the block counts the ones on every lane and presents the per-lane counts as binary results with a one-cycle done pulse. It sits at the output of unary compute arrays, before binary write-back.

---
 rtl/unary_decode_array.sv | 87 ++++++++
 tb/tb_unary_decode_array.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/unary_decode_array.sv
// rtl/unary_decode_array.sv - per-lane ones counter over one 2^RWID-cycle RNG period
// Decodes LANES unary bitstreams back to binary counts, one window per start request.
`timescale 1ns/1ps
module unary_decode_array #(
  parameter  int RWID  = 10,
  parameter  int LANES = 32,
  localparam int NL    = (LANES < 1) ? 1 : LANES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            start,
  input  logic [NL-1:0]   bitIn,
  output logic            busy,
  output logic            done,
  output logic [RWID:0]   result [NL]
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  localparam logic [RWID-1:0] CNT_LAST = '1;

  state_t          state_q, state_d;
  logic [RWID-1:0] cnt_q, cnt_d;
  logic [RWID:0]   acc_q [NL];
  logic [RWID:0]   acc_d [NL];
  logic [RWID:0]   result_q [NL];
  logic [RWID:0]   result_d [NL];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int k = 0; k < NL; k++) acc_d[k] = '0;
          cnt_d   = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        // Stalled cycles leave both the counts and the window position untouched.
        if (enable) begin
          for (int k = 0; k < NL; k++) acc_d[k] = acc_q[k] + (RWID+1)'(bitIn[k]);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            result_d = acc_d;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          for (int k = 0; k < NL; k++) acc_d[k] = '0;
          cnt_d   = '0;
          state_d = S_ACC;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      for (int k = 0; k < NL; k++) begin
        acc_q[k]    <= '0;
        result_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_ACC);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_unary_decode_array.sv
// tb/tb_unary_decode_array.sv - directed bench for unary_decode_array (RWID=4, LANES=4)
`timescale 1ns/1ps
module tb_unary_decode_array;
  localparam int RWID  = 4;
  localparam int LANES = 4;
  localparam int N     = 16;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             enable = 1'b0;
  logic             start  = 1'b0;
  logic [LANES-1:0] bitIn  = '0;
  logic             busy;
  logic             done;
  logic [RWID:0]    result [LANES];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  unary_decode_array #(.RWID(RWID), .LANES(LANES)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .start  (start),
    .bitIn  (bitIn),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // lane0 ones, lane1 zeros, lane2 1010..., lane3 one only on the last sample
  function automatic logic [3:0] pat(input int i);
    pat = {(i == N), i[0], 1'b0, 1'b1};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; enable = 1'b0; bitIn = '0;
    repeat (3) step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    for (int k = 0; k < LANES; k++) begin
      total++;
      if (result[k] !== 5'd0) begin bad++; $display("FAIL reset_result lane%0d got=%0d exp=0", k, result[k]); end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      enable = c[0];
      bitIn  = 4'hF;
      step();
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL idle_quiet cycle%0d got busy=%b done=%b exp 0/0", c, busy, done);
      end
    end
    for (int k = 0; k < LANES; k++) begin
      total++;
      if (result[k] !== 5'd0) begin bad++; $display("FAIL idle_result lane%0d got=%0d exp=0", k, result[k]); end
    end
  endtask

  task automatic test_extremes();
    int exp_r [LANES] = '{16, 0, 8, 1};
    start = 1'b1; enable = 1'b1; bitIn = 4'hF;
    step();
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ext_busy_c1 got=%b exp=1", busy); end
    for (int i = 1; i <= N; i++) begin
      bitIn = pat(i);
      step();
      if (i < N) begin
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          bad++; $display("FAIL ext_progress cycle%0d got busy=%b done=%b exp 1/0", i + 1, busy, done);
        end
      end
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL ext_done_c17 got=%b exp=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ext_busy_c17 got=%b exp=0", busy); end
    for (int k = 0; k < LANES; k++) begin
      total++;
      if (result[k] !== exp_r[k]) begin bad++; $display("FAIL ext_result lane%0d got=%0d exp=%0d", k, result[k], exp_r[k]); end
    end
    bitIn = '0;
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL ext_done_width got=%b exp=0", done); end
  endtask

  task automatic test_sobol();
    logic [3:0] src [LANES] = '{4'd0, 4'd5, 4'd11, 4'd15};
    logic [3:0] s;
    int n;
    int c;
    start = 1'b1; enable = 1'b1; bitIn = '0;
    step();
    start = 1'b0;
    s = '0;
    n = 0;
    for (int i = 1; i <= N; i++) begin
      for (int k = 0; k < LANES; k++) bitIn[k] = (src[k] > s);
      step();
      c = 0;
      while (((n >> c) & 1) == 1) c++;
      s = s ^ (4'b1000 >> c);
      n++;
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL sobol_done got=%b exp=1", done); end
    for (int k = 0; k < LANES; k++) begin
      total++;
      if (result[k] !== {1'b0, src[k]}) begin bad++; $display("FAIL sobol_result lane%0d got=%0d exp=%0d", k, result[k], src[k]); end
    end
    bitIn = '0;
    step();
  endtask

  task automatic test_stall_and_start();
    int exp_r [LANES] = '{16, 0, 8, 1};
    int i;
    int dones;
    logic stall;
    start = 1'b1; enable = 1'b1; bitIn = 4'hF;
    step();
    i = 1;
    dones = 0;
    for (int cyc = 1; cyc <= 19; cyc++) begin
      stall  = (cyc == 4 || cyc == 9 || cyc == 13);
      enable = !stall;
      if (stall) bitIn = 4'hF;
      else begin bitIn = pat(i); i++; end
      start = (cyc == 7);
      step();
      if (done) dones++;
      if (cyc + 1 < 20) begin
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL stall_early_done cycle%0d got=%b exp=0", cyc + 1, done); end
      end
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL stall_done_c20 got=%b exp=1", done); end
    for (int k = 0; k < LANES; k++) begin
      total++;
      if (result[k] !== exp_r[k]) begin bad++; $display("FAIL stall_result lane%0d got=%0d exp=%0d", k, result[k], exp_r[k]); end
    end
    start = 1'b0; enable = 1'b1; bitIn = '0;
    repeat (5) begin
      step();
      if (done) dones++;
    end
    total++; if (dones !== 1) begin bad++; $display("FAIL stall_done_count got=%0d exp=1", dones); end
  endtask

  task automatic test_reset_mid_window();
    int exp_r [LANES] = '{16, 0, 8, 1};
    start = 1'b1; enable = 1'b1; bitIn = 4'hF;
    step();
    start = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
    for (int k = 0; k < LANES; k++) begin
      total++;
      if (result[k] !== 5'd0) begin bad++; $display("FAIL rstmid_result lane%0d got=%0d exp=0", k, result[k]); end
    end
    step();
    rst_n = 1'b1;
    step();
    start = 1'b1; enable = 1'b1; bitIn = 4'hF;
    step();
    start = 1'b0;
    for (int i = 1; i <= N; i++) begin
      bitIn = pat(i);
      step();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL rstmid_redo_done got=%b exp=1", done); end
    for (int k = 0; k < LANES; k++) begin
      total++;
      if (result[k] !== exp_r[k]) begin bad++; $display("FAIL rstmid_redo_result lane%0d got=%0d exp=%0d", k, result[k], exp_r[k]); end
    end
    bitIn = '0;
    step();
  endtask

  task automatic test_back_to_back();
    start = 1'b1; enable = 1'b1; bitIn = 4'b0001;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++; $display("FAIL b2b_win1 cycle%0d got busy=%b done=%b exp 1/0", cyc, busy, done);
      end
      step();
    end
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL b2b_done1 got busy=%b done=%b exp 0/1", busy, done); end
    total++; if (result[0] !== 5'd16) begin bad++; $display("FAIL b2b_result1 got=%0d exp=16", result[0]); end
    start = 1'b1;
    step();
    start = 1'b0;
    bitIn = '0;
    for (int cyc = 18; cyc <= 33; cyc++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++; $display("FAIL b2b_win2 cycle%0d got busy=%b done=%b exp 1/0", cyc, busy, done);
      end
      step();
    end
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL b2b_done2 got busy=%b done=%b exp 0/1", busy, done); end
    total++; if (result[0] !== 5'd0) begin bad++; $display("FAIL b2b_result2 got=%0d exp=0", result[0]); end
    step();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL b2b_after got busy=%b done=%b exp 0/0", busy, done); end
  endtask

  initial begin
    test_reset();
    test_extremes();
    test_sobol();
    test_stall_and_start();
    test_reset_mid_window();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
